// File: rtl/rc_servo_core_nch_if.sv
// Bus bundle for rc_servo_core_nch: comparator/enable inputs, pulse/position/frame outputs.
// master = driving environment, slave = servo core.
interface rc_servo_core_nch_if #(
  parameter int unsigned CH_N  = 2,
  parameter int unsigned ADC_W = 10
);
  logic [CH_N-1:0]       comp_async_i;
  logic [CH_N-1:0]       en_i;
  logic [CH_N-1:0]       pwm_o;
  logic [CH_N*ADC_W-1:0] pos_o;
  logic                  frame_o;

  modport master (
    output comp_async_i,
    output en_i,
    input  pwm_o,
    input  pos_o,
    input  frame_o
  );

  modport slave (
    input  comp_async_i,
    input  en_i,
    output pwm_o,
    output pos_o,
    output frame_o
  );
endinterface

// File: rtl/rc_servo_core_nch.sv
// N-channel RC-servo core: per-frame comparator duty measurement sets each channel's pulse width.
// Define RC_SERVO_FILTER_EN to average new measurements into the position (round-half-up).
module rc_servo_core_nch #(
  parameter int unsigned CH_N         = 2,
  parameter int unsigned ADC_W        = 10,
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned PW_MIN_TICKS = 1000,
  parameter int unsigned FRAME_TICKS  = 20000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  rc_servo_core_nch_if.slave bus_io
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned FrameW = $clog2(FRAME_TICKS);
  localparam int unsigned CmpW   = FrameW + 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_TICKS - 1);
  localparam logic [CmpW-1:0]   WinTicks  = CmpW'((2 ** ADC_W) - 1);
  localparam logic [CmpW-1:0]   PwMin     = CmpW'(PW_MIN_TICKS);
  localparam logic [ADC_W-1:0]  PosReset  = ADC_W'(2 ** (ADC_W - 1));

  if ((CH_N < 1) || (CH_N > 8)) begin : g_chk_ch
    $error("rc_servo_core_nch: CH_N must be in 1..8");
  end
  if (TICK_DIV < 2) begin : g_chk_tick
    $error("rc_servo_core_nch: TICK_DIV must be at least 2");
  end
  if (FRAME_TICKS < PW_MIN_TICKS + (2 ** ADC_W)) begin : g_chk_frame
    $error("rc_servo_core_nch: FRAME_TICKS must be >= PW_MIN_TICKS + 2**ADC_W");
  end

  logic [CH_N-1:0]             sync1_q, sync2_q;
  logic [TickW-1:0]            tick_cnt_q, tick_cnt_d;
  logic [FrameW-1:0]           frame_cnt_q, frame_cnt_d;
  logic [CH_N-1:0][ADC_W-1:0]  meas_q, meas_d;
  logic [CH_N-1:0][ADC_W-1:0]  pos_q, pos_d;
  logic [CH_N-1:0]             en_r_q, en_r_d;
  logic [CH_N-1:0]             pwm_q, pwm_d;
  logic [CH_N-1:0]             comp_s;
  logic                        tick, boundary, in_window;
`ifdef RC_SERVO_FILTER_EN
  logic [ADC_W:0]              filt_sum;
`endif

  assign comp_s    = sync2_q;
  assign tick      = (tick_cnt_q == TickLast);
  assign boundary  = tick && (frame_cnt_q == FrameLast);
  assign in_window = ({1'b0, frame_cnt_q} < WinTicks);

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TickW'(1);
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = boundary ? '0 : frame_cnt_q + FrameW'(1);
    end
    meas_d = meas_q;
    pos_d  = pos_q;
    en_r_d = en_r_q;
    pwm_d  = '0;
`ifdef RC_SERVO_FILTER_EN
    filt_sum = '0;
`endif
    for (int k = 0; k < CH_N; k++) begin
      // Boundary never lies inside the window, so clear and increment cannot collide.
      if (boundary) begin
        meas_d[k] = '0;
`ifdef RC_SERVO_FILTER_EN
        filt_sum = {1'b0, pos_q[k]} + {1'b0, meas_q[k]} + (ADC_W + 1)'(1);
        pos_d[k] = filt_sum[ADC_W:1];
`else
        pos_d[k] = meas_q[k];
`endif
      end else if (tick && in_window && comp_s[k]) begin
        meas_d[k] = meas_q[k] + ADC_W'(1);
      end
      pwm_d[k] = en_r_q[k] & ({1'b0, frame_cnt_q} < (PwMin + CmpW'(pos_q[k])));
    end
    if (boundary) begin
      en_r_d = bus_io.en_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tick_cnt_q  <= '0;
      frame_cnt_q <= '0;
      meas_q      <= '0;
      pos_q       <= {CH_N{PosReset}};
      en_r_q      <= '0;
      pwm_q       <= '0;
    end else begin
      sync1_q     <= bus_io.comp_async_i;
      sync2_q     <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      meas_q      <= meas_d;
      pos_q       <= pos_d;
      en_r_q      <= en_r_d;
      pwm_q       <= pwm_d;
    end
  end

  assign bus_io.pwm_o   = pwm_q;
  assign bus_io.pos_o   = pos_q;
  assign bus_io.frame_o = boundary;

endmodule

// File: tb/tb_rc_servo_core_nch.sv
// Self-checking bench for rc_servo_core_nch: cycle-indexed reference model, directed and random stimulus.
module tb_rc_servo_core_nch;
  localparam int unsigned CH_N         = 2;
  localparam int unsigned ADC_W        = 4;
  localparam int unsigned TICK_DIV     = 2;
  localparam int unsigned PW_MIN_TICKS = 8;
  localparam int unsigned FRAME_TICKS  = 40;
  localparam int FrameCyc  = TICK_DIV * FRAME_TICKS;
  localparam int WinTicks  = (1 << ADC_W) - 1;
  localparam int PosCentre = 1 << (ADC_W - 1);
  localparam int MaxCyc    = 600;
  localparam int MaxFrm    = 8;

  logic clk = 1'b0;
  logic rst;

  rc_servo_core_nch_if #(.CH_N(CH_N), .ADC_W(ADC_W)) bus ();

  rc_servo_core_nch #(
    .CH_N        (CH_N),
    .ADC_W       (ADC_W),
    .TICK_DIV    (TICK_DIV),
    .PW_MIN_TICKS(PW_MIN_TICKS),
    .FRAME_TICKS (FRAME_TICKS)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Stimulus history and per-frame model/observation, indexed by cycles since reset release.
  bit drv    [CH_N][MaxCyc];
  bit en_drv [CH_N][MaxCyc];
  int pos_m  [CH_N][MaxFrm];
  bit en_m   [CH_N][MaxFrm];
  int pos_obs   [CH_N][MaxFrm];
  int width_obs [CH_N][MaxFrm];
  logic [CH_N-1:0] ev_rand;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Duty count of frame f: window ticks whose synchronised sample (drive 2 cycles earlier) was high.
  function automatic int meas_of(input int k, input int f);
    int m = 0;
    int c;
    for (int t = 0; t < WinTicks; t++) begin
      c = f * FrameCyc + t * TICK_DIV + (TICK_DIV - 1);
      if (c >= 2 && drv[k][c-2]) m++;
    end
    return m;
  endfunction

  function automatic int next_pos(input int old_pos, input int meas);
`ifdef RC_SERVO_FILTER_EN
    return (old_pos + meas + 1) / 2;
`else
    return meas;
`endif
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.comp_async_i = '0;
    bus.en_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_pwm_o", int'(bus.pwm_o), 0);
    check_eq("rst_frame_o", int'(bus.frame_o), 0);
    check_eq("rst_pos_o", int'(bus.pos_o), (PosCentre << ADC_W) | PosCentre);
    for (int k = 0; k < CH_N; k++) begin
      for (int i = 0; i < MaxCyc; i++) begin
        drv[k][i] = 1'b0;
        en_drv[k][i] = 1'b0;
      end
      for (int f = 0; f < MaxFrm; f++) begin
        width_obs[k][f] = 0;
        pos_obs[k][f] = -1;
      end
      pos_m[k][0] = PosCentre;
      en_m[k][0] = 1'b0;
    end
    ev_rand = '1;
    rst = 1'b0;
  endtask

  task automatic run_phase(input int mode, input int ncyc);
    int f, fp, fc, exp_pwm, r;
    bit p;
    logic [CH_N-1:0] cv, ev;
    for (int c = 0; c < ncyc; c++) begin
      f = c / FrameCyc;
      if (c > 0 && (c % FrameCyc) == 0) begin
        for (int k = 0; k < CH_N; k++) begin
          pos_m[k][f] = next_pos(pos_m[k][f-1], meas_of(k, f - 1));
          en_m[k][f]  = en_drv[k][c-1];
        end
      end
      check_eq($sformatf("frame_o@%0d", c), int'(bus.frame_o),
               ((c % FrameCyc) == FrameCyc - 1) ? 1 : 0);
      for (int k = 0; k < CH_N; k++) begin
        check_eq($sformatf("pos_o[%0d]@%0d", k, c), int'(bus.pos_o[k*ADC_W +: ADC_W]),
                 pos_m[k][f]);
        exp_pwm = 0;
        if (c > 0) begin
          fp = (c - 1) / FrameCyc;
          fc = ((c - 1) / TICK_DIV) % FRAME_TICKS;
          exp_pwm = (en_m[k][fp] && (fc < PW_MIN_TICKS + pos_m[k][fp])) ? 1 : 0;
        end
        check_eq($sformatf("pwm_o[%0d]@%0d", k, c), int'(bus.pwm_o[k]), exp_pwm);
        if (bus.pwm_o[k]) width_obs[k][f]++;
        if ((c % FrameCyc) == 1) pos_obs[k][f] = int'(bus.pos_o[k*ADC_W +: ADC_W]);
      end
      case (mode)
        0: begin
          cv = 2'b01;
          ev = 2'b11;
        end
        1: begin
          cv = 2'($urandom_range(0, 3));
          ev = {1'b1, (c < 2 * FrameCyc + 10)};
        end
        2: begin
          r  = (c + 2) % FrameCyc;
          p  = (r >= 1) && (r <= 11);
          cv = {~p, p};
          ev = 2'b11;
        end
        default: begin
          cv = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) ev_rand[$urandom_range(0, 1)] ^= 1'b1;
          ev = ev_rand;
        end
      endcase
      for (int k = 0; k < CH_N; k++) begin
        drv[k][c] = cv[k];
        en_drv[k][c] = ev[k];
      end
      bus.comp_async_i = cv;
      bus.en_i = ev;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.comp_async_i = '0;
    bus.en_i = '0;
    @(negedge clk);

    // Full scale on channel 0, zero scale on channel 1, then reset mid-pulse.
    apply_reset();
    run_phase(0, 4 * FrameCyc + 12);
`ifndef RC_SERVO_FILTER_EN
    check_eq("full_pos_f2", pos_obs[0][2], 15);
    check_eq("full_width_f2", width_obs[0][2], 46);
    check_eq("full_width_f3", width_obs[0][3], 46);
    check_eq("zero_pos_f2", pos_obs[1][2], 0);
    check_eq("zero_width_f2", width_obs[1][2], 16);
`else
    check_eq("filt_pos_f1", pos_obs[0][1], 11);
    check_eq("filt_pos_f2", pos_obs[0][2], 13);
    check_eq("filt_pos_f3", pos_obs[0][3], 14);
    check_eq("filt_pos_f4", pos_obs[0][4], 15);
`endif
    check_eq("pre_rst_pwm", int'(bus.pwm_o[0]), 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_pwm_o", int'(bus.pwm_o), 0);
    check_eq("midrst_pos_o", int'(bus.pos_o), (PosCentre << ADC_W) | PosCentre);
    check_eq("midrst_frame_o", int'(bus.frame_o), 0);

    // Enable dropped mid-pulse in frame 2.
    apply_reset();
    run_phase(1, 4 * FrameCyc);
    check_eq("endrop_full_f2", width_obs[0][2], 2 * (PW_MIN_TICKS + pos_m[0][2]));
    check_eq("endrop_none_f3", width_obs[0][3], 0);

    // Comparator high for the first 6 window ticks.
    apply_reset();
    run_phase(2, 4 * FrameCyc);
`ifndef RC_SERVO_FILTER_EN
    check_eq("duty6_pos_f2", pos_obs[0][2], 6);
    check_eq("duty6_width_f2", width_obs[0][2], 28);
`endif

    // Random comparator and enable activity.
    apply_reset();
    run_phase(3, 6 * FrameCyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
